// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART:
// register offsets, STATUS/CTRL bit positions and engine states.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_DONE  = 1;
  localparam int ST_RX_AVAIL = 2;
  localparam int ST_RXOVR    = 3;
  localparam int ST_FRAMERR  = 4;
  localparam int ST_TXOVF    = 5;
  localparam int ST_RXCNT    = 8;

  localparam int CTRL_LOOP = 16;
  localparam int CTRL_RXIE = 17;
  localparam int CTRL_TXIE = 18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop on a full
// FIFO frees the slot so a same-cycle push is accepted.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_mmio.sv
// UART peripheral on the IO page: TX/RX FIFOs, runtime divisor,
// loopback, sticky error flags and a level interrupt.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int DIV_WIDTH = 16,
  parameter int DIV_RESET = 234
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic [1:0]  word_addr_i,
  input  logic        rstrb_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wmask_i,
  output logic [31:0] rdata_o,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);

  logic [DIV_WIDTH-1:0] div_q, div_d, div_new;
  logic loop_q, loop_d, rxie_q, rxie_d, txie_q, txie_d;
  logic rxovr_q, rxovr_d, ferr_q, ferr_d, txovf_q, txovf_d;
  logic [31:0] rdata_q, rdata_d, st_w, ctrl_w;

  logic rd, wr, tx_push, rx_pop, st_wr, ctrl_wr;
  logic tx_pop, tx_full, tx_empty, tx_done;
  logic rx_push, rx_full, rx_empty, ferr_set;
  logic [7:0] tx_head, rx_head;
  logic [TAW:0] tx_cnt;
  logic [RAW:0] rx_cnt;

  uart_state_e txs_q, txs_d, rxs_q, rxs_d;
  logic [DIV_WIDTH-1:0] tcnt_q, tcnt_d, tdiv_q, tdiv_d;
  logic [DIV_WIDTH-1:0] rcnt_q, rcnt_d, rdiv_q, rdiv_d;
  logic [2:0] tbit_q, tbit_d, rbit_q, rbit_d;
  logic [7:0] tsh_q, tsh_d, rsh_q, rsh_d;
  logic tx_q, tx_d, load;
  logic sync1_q, sync2_q, prev_q, line;
  logic unused_ok;

  assign unused_ok = ^wdata_i[31:19];

  assign rd      = sel_i & rstrb_i;
  assign wr      = sel_i & |wmask_i;
  assign tx_push = wr & wmask_i[0] & (word_addr_i == REG_DATA);
  assign st_wr   = wr & wmask_i[0] & (word_addr_i == REG_STATUS);
  assign ctrl_wr = wr & (word_addr_i == REG_CTRL);
  assign rx_pop  = rd & (word_addr_i == REG_DATA);

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_txf (
    .clk_i, .rst_i,
    .push_i(tx_push), .wdata_i(wdata_i[7:0]), .pop_i(tx_pop),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty),
    .count_o(tx_cnt)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rxf (
    .clk_i, .rst_i,
    .push_i(rx_push), .wdata_i(rsh_q), .pop_i(rx_pop),
    .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty),
    .count_o(rx_cnt)
  );

  assign tx_done = (tx_cnt == '0) & (txs_q == S_IDLE);
  assign line    = loop_q ? tx_q : sync2_q;
  assign tx_o    = tx_q;
  assign rdata_o = rdata_q;
  assign irq_o   = (rxie_q & ~rx_empty) | (txie_q & tx_done) |
                   rxovr_q | ferr_q;

  always_comb begin
    st_w = '0;
    st_w[ST_TX_FULL]  = tx_full;
    st_w[ST_TX_DONE]  = tx_done;
    st_w[ST_RX_AVAIL] = ~rx_empty;
    st_w[ST_RXOVR]    = rxovr_q;
    st_w[ST_FRAMERR]  = ferr_q;
    st_w[ST_TXOVF]    = txovf_q;
    st_w[ST_RXCNT+:8] = 8'(rx_cnt);
    ctrl_w = '0;
    ctrl_w[DIV_WIDTH-1:0] = div_q;
    ctrl_w[CTRL_LOOP] = loop_q;
    ctrl_w[CTRL_RXIE] = rxie_q;
    ctrl_w[CTRL_TXIE] = txie_q;
  end

  // Register file: byte-masked CTRL update, W1C flags, read mux
  always_comb begin
    div_new = div_q;
    for (int i = 0; i < DIV_WIDTH; i++)
      if (wmask_i[i/8]) div_new[i] = wdata_i[i];
    div_d  = div_q;
    loop_d = loop_q;
    rxie_d = rxie_q;
    txie_d = txie_q;
    if (ctrl_wr) begin
      div_d  = (div_new < TWO) ? TWO : div_new;
      loop_d = wmask_i[2] ? wdata_i[CTRL_LOOP] : loop_q;
      rxie_d = wmask_i[2] ? wdata_i[CTRL_RXIE] : rxie_q;
      txie_d = wmask_i[2] ? wdata_i[CTRL_TXIE] : txie_q;
    end
    rxovr_d = (rxovr_q & ~(st_wr & wdata_i[ST_RXOVR])) |
              (rx_push & rx_full & ~rx_pop);
    ferr_d  = (ferr_q & ~(st_wr & wdata_i[ST_FRAMERR])) | ferr_set;
    txovf_d = (txovf_q & ~(st_wr & wdata_i[ST_TXOVF])) |
              (tx_push & tx_full & ~tx_pop);
    rdata_d = rdata_q;
    if (rd) begin
      unique case (word_addr_i)
        REG_DATA:   rdata_d = rx_empty ? '0 : {24'b0, rx_head};
        REG_STATUS: rdata_d = st_w;
        REG_CTRL:   rdata_d = ctrl_w;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    txs_d  = txs_q;
    tcnt_d = tcnt_q - ONE;
    tdiv_d = tdiv_q;
    tbit_d = tbit_q;
    tsh_d  = tsh_q;
    tx_d   = tx_q;
    tx_pop = 1'b0;
    load   = 1'b0;
    unique case (txs_q)
      S_IDLE: load = ~tx_empty;
      S_START:
        if (tcnt_q == '0) begin
          tx_d   = tsh_q[0];
          tsh_d  = tsh_q >> 1;
          tbit_d = 3'd0;
          tcnt_d = tdiv_q - ONE;
          txs_d  = S_DATA;
        end
      S_DATA:
        if (tcnt_q == '0) begin
          tcnt_d = tdiv_q - ONE;
          if (tbit_q == 3'd7) begin
            tx_d  = 1'b1;
            txs_d = S_STOP;
          end else begin
            tx_d   = tsh_q[0];
            tsh_d  = tsh_q >> 1;
            tbit_d = tbit_q + 3'd1;
          end
        end
      S_STOP:
        if (tcnt_q == '0) begin
          if (tx_empty) txs_d = S_IDLE;
          else          load  = 1'b1;
        end
    endcase
    // Divisor is latched per frame so CTRL writes hit the next one
    if (load) begin
      tx_pop = 1'b1;
      tsh_d  = tx_head;
      tdiv_d = div_q;
      tcnt_d = div_q - ONE;
      tx_d   = 1'b0;
      txs_d  = S_START;
    end
  end

  always_comb begin
    rxs_d    = rxs_q;
    rcnt_d   = rcnt_q - ONE;
    rdiv_d   = rdiv_q;
    rbit_d   = rbit_q;
    rsh_d    = rsh_q;
    rx_push  = 1'b0;
    ferr_set = 1'b0;
    unique case (rxs_q)
      S_IDLE:
        if (prev_q & ~line) begin
          rdiv_d = div_q;
          rcnt_d = (div_q >> 1) - ONE;
          rxs_d  = S_START;
        end
      S_START:
        if (rcnt_q == '0) begin
          rcnt_d = rdiv_q - ONE;
          rbit_d = 3'd0;
          rxs_d  = line ? S_IDLE : S_DATA;
        end
      S_DATA:
        if (rcnt_q == '0) begin
          rsh_d  = {line, rsh_q[7:1]};
          rcnt_d = rdiv_q - ONE;
          rbit_d = rbit_q + 3'd1;
          if (rbit_q == 3'd7) rxs_d = S_STOP;
        end
      S_STOP:
        if (rcnt_q == '0) begin
          rx_push  = line;
          ferr_set = ~line;
          rxs_d    = S_IDLE;
        end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= DIV_WIDTH'(DIV_RESET);
      loop_q  <= 1'b0;
      rxie_q  <= 1'b0;
      txie_q  <= 1'b0;
      rxovr_q <= 1'b0;
      ferr_q  <= 1'b0;
      txovf_q <= 1'b0;
      rdata_q <= '0;
      txs_q   <= S_IDLE;
      tcnt_q  <= '0;
      tdiv_q  <= '0;
      tbit_q  <= '0;
      tsh_q   <= '0;
      tx_q    <= 1'b1;
      rxs_q   <= S_IDLE;
      rcnt_q  <= '0;
      rdiv_q  <= '0;
      rbit_q  <= '0;
      rsh_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      div_q   <= div_d;
      loop_q  <= loop_d;
      rxie_q  <= rxie_d;
      txie_q  <= txie_d;
      rxovr_q <= rxovr_d;
      ferr_q  <= ferr_d;
      txovf_q <= txovf_d;
      rdata_q <= rdata_d;
      txs_q   <= txs_d;
      tcnt_q  <= tcnt_d;
      tdiv_q  <= tdiv_d;
      tbit_q  <= tbit_d;
      tsh_q   <= tsh_d;
      tx_q    <= tx_d;
      rxs_q   <= rxs_d;
      rcnt_q  <= rcnt_d;
      rdiv_q  <= rdiv_d;
      rbit_q  <= rbit_d;
      rsh_q   <= rsh_d;
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= line;
    end
  end

endmodule
